// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer: command codes,
// FSM states, access sizes and the command decoder.
package dmem_access_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] CMD_LB  = 4'b1000;
  localparam logic [3:0] CMD_LH  = 4'b1001;
  localparam logic [3:0] CMD_LW  = 4'b1010;
  localparam logic [3:0] CMD_SB  = 4'b1011;
  localparam logic [3:0] CMD_LBU = 4'b1100;
  localparam logic [3:0] CMD_LHU = 4'b1101;
  localparam logic [3:0] CMD_SH  = 4'b1110;
  localparam logic [3:0] CMD_SW  = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_ERR} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic  legal;
    logic  store;
    logic  uns;
    size_e sz;
  } cmd_dec_t;

  // Split a decode command into size / direction / signedness.
  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d.legal = 1'b1;
    d.store = 1'b0;
    d.uns   = 1'b0;
    d.sz    = SZ_W;
    case (cmd)
      CMD_LB:  d.sz = SZ_B;
      CMD_LH:  d.sz = SZ_H;
      CMD_LW:  d.sz = SZ_W;
      CMD_LBU: begin d.sz = SZ_B; d.uns = 1'b1; end
      CMD_LHU: begin d.sz = SZ_H; d.uns = 1'b1; end
      CMD_SB:  begin d.sz = SZ_B; d.store = 1'b1; end
      CMD_SH:  begin d.sz = SZ_H; d.store = 1'b1; end
      CMD_SW:  begin d.sz = SZ_W; d.store = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane steering: byte enables, store-data replication and load
// extract/extend. Purely combinational so a store buffer can reuse it.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]      i_sz,
  input  logic [1:0]      i_lo,
  input  logic            i_uns,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_shr;

  // Move the addressed lane down to bit 0 before extension
  assign w_shr = i_rdata >> {i_lo, 3'b000};

  // Per-size lane mapping; word access passes everything through
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_sz)
      SZ_B: begin
        o_be    = 4'b0001 << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_uns & w_shr[7]}}, w_shr[7:0]};
      end
      SZ_H: begin
        o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_uns & w_shr[15]}}, w_shr[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: accepts one decoded memory command, runs a
// single req/ack bus transaction, stalls the core meanwhile, and reports
// misaligned accesses, illegal codes and bus timeouts.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      MEM_CMD,
  input  logic [XLEN-1:0] ADDR,
  input  logic [XLEN-1:0] WDATA,
  output logic            STALL,
  output logic [XLEN-1:0] RDATA,
  output logic            EXC_MISALIGN,
  output logic            EXC_BUS,
  output logic            BUS_REQ,
  output logic            BUS_WE,
  output logic [XLEN-1:0] BUS_ADDR,
  output logic [3:0]      BUS_BE,
  output logic [XLEN-1:0] BUS_WDATA,
  input  logic [XLEN-1:0] BUS_RDATA,
  input  logic            BUS_ACK
);

  localparam logic [7:0] TO_INIT = 8'(TIMEOUT);

  state_e          r_state, w_nxt;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [3:0]      r_be;
  logic            r_we, r_uns, r_exc_mis, r_exc_bus;
  logic [1:0]      r_lo;
  size_e           r_sz;

  cmd_dec_t        w_dec;
  logic            w_start, w_cap, w_mis, w_ebus;
  size_e           w_sz;
  logic [1:0]      w_lo;
  logic            w_uns;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wrep, w_rext;

  assign w_dec = decode_cmd(MEM_CMD);

  // Lane unit sees the live command while idle and the latched one while busy
  assign w_sz  = (r_state == ST_IDLE) ? w_dec.sz     : r_sz;
  assign w_lo  = (r_state == ST_IDLE) ? ADDR[1:0]    : r_lo;
  assign w_uns = (r_state == ST_IDLE) ? w_dec.uns    : r_uns;

  dmem_lane_align u_align (
    .i_sz    (w_sz),
    .i_lo    (w_lo),
    .i_uns   (w_uns),
    .i_wdata (WDATA),
    .i_rdata (BUS_RDATA),
    .o_be    (w_be),
    .o_wdata (w_wrep),
    .o_rdata (w_rext)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  // Next state plus one-cycle strobes for the datapath
  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_cap   = 1'b0;
    w_mis   = 1'b0;
    w_ebus  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MEM_CMD[3]) begin
          if (!w_dec.legal) begin
            w_nxt  = ST_ERR;
            w_ebus = 1'b1;
          end else if (misaligned(w_dec.sz, ADDR[1:0])) begin
            w_nxt = ST_ERR;
            w_mis = 1'b1;
          end else begin
            w_nxt   = ST_BUSY;
            w_start = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // ACK beats a simultaneous counter expiry
        if (BUS_ACK) begin
          w_nxt = ST_DONE;
          w_cap = 1'b1;
        end else if (r_cnt <= 8'd1) begin
          w_nxt  = ST_ERR;
          w_ebus = 1'b1;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Bus output registers, timeout counter, load result and exception pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_lo      <= '0;
      r_sz      <= SZ_W;
      r_exc_mis <= 1'b0;
      r_exc_bus <= 1'b0;
    end else begin
      r_exc_mis <= w_mis;
      r_exc_bus <= w_ebus;
      if (w_start) begin
        r_cnt   <= TO_INIT;
        r_addr  <= {ADDR[XLEN-1:2], 2'b00};
        r_wdata <= w_wrep;
        r_be    <= w_be;
        r_we    <= w_dec.store;
        r_uns   <= w_dec.uns;
        r_lo    <= ADDR[1:0];
        r_sz    <= w_dec.sz;
      end else if (r_state == ST_BUSY && !BUS_ACK) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_cap && !r_we) r_rdata <= w_rext;
    end
  end

  assign STALL        = MEM_CMD[3] & ((r_state == ST_IDLE) | (r_state == ST_BUSY));
  assign BUS_REQ      = (r_state == ST_BUSY);
  assign BUS_WE       = r_we;
  assign BUS_ADDR     = r_addr;
  assign BUS_BE       = r_be;
  assign BUS_WDATA    = r_wdata;
  assign RDATA        = r_rdata;
  assign EXC_MISALIGN = r_exc_mis;
  assign EXC_BUS      = r_exc_bus;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table of accesses driven through a scoreboard
// queue, plus hand sequences for reset-in-flight and back-to-back commands.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  MEM_CMD;
  logic [31:0] ADDR, WDATA, RDATA, BUS_ADDR, BUS_WDATA, BUS_RDATA;
  logic        STALL, EXC_MISALIGN, EXC_BUS, BUS_REQ, BUS_WE, BUS_ACK;
  logic [3:0]  BUS_BE;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .MEM_CMD(MEM_CMD), .ADDR(ADDR), .WDATA(WDATA),
    .STALL(STALL), .RDATA(RDATA), .EXC_MISALIGN(EXC_MISALIGN), .EXC_BUS(EXC_BUS),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] addr, wdata, brd;
    int          ack_k;      // ACK in the k-th request cycle; 0 = never
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_rdata;
    int          e_req;      // expected number of BUS_REQ cycles
    logic        e_mis, e_bus;
  } vec_t;

  vec_t vq[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] cmd,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] brd,
      input int ack_k, input logic [31:0] e_addr, input logic [3:0] e_be,
      input logic e_we, input logic [31:0] e_wdata, input logic [31:0] e_rdata,
      input int e_req, input logic e_mis, input logic e_bus);
    vec_t v;
    v.name = nm; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.brd = brd;
    v.ack_k = ack_k; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_req = e_req;
    v.e_mis = e_mis; v.e_bus = e_bus;
    return v;
  endfunction

  // Monitor: counts request cycles, snapshots bus outputs, and on each
  // completion (DONE/ERR) pops the oldest expectation and compares.
  initial begin
    int          mreq;
    logic        prev_req;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    logic        m_we;
    vec_t        e;
    mreq = 0; prev_req = 1'b0;
    m_addr = '0; m_wd = '0; m_be = '0; m_we = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST || !mon_en) begin
        mreq = 0; prev_req = 1'b0;
      end else begin
        if (BUS_REQ) begin
          if (mreq == 0) begin
            m_addr = BUS_ADDR; m_wd = BUS_WDATA; m_be = BUS_BE; m_we = BUS_WE;
          end else if (BUS_ADDR !== m_addr || BUS_BE !== m_be || BUS_WDATA !== m_wd) begin
            chk("bus_stable", BUS_ADDR, m_addr);
          end
          mreq++;
        end
        if (EXC_MISALIGN || EXC_BUS || (prev_req && !BUS_REQ)) begin
          if (vq.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = vq.pop_front();
            chk({e.name, " exc_mis"}, 32'(EXC_MISALIGN), 32'(e.e_mis));
            chk({e.name, " exc_bus"}, 32'(EXC_BUS), 32'(e.e_bus));
            chk({e.name, " req_cycles"}, 32'(mreq), 32'(e.e_req));
            chk({e.name, " stall_end"}, 32'(STALL), 32'd0);
            if (e.e_req > 0) begin
              chk({e.name, " bus_addr"}, m_addr, e.e_addr);
              chk({e.name, " bus_be"}, 32'(m_be), 32'(e.e_be));
              chk({e.name, " bus_we"}, 32'(m_we), 32'(e.e_we));
              if (e.e_we) chk({e.name, " bus_wdata"}, m_wd, e.e_wdata);
            end
            if (!e.e_mis && !e.e_bus) chk({e.name, " rdata"}, RDATA, e.e_rdata);
          end
          mreq = 0;
        end
        prev_req = BUS_REQ;
      end
    end
  end

  // Drive one access; hold the command until the monitor sees completion.
  task automatic run(input vec_t v);
    int c;
    @(posedge CLK); #1;
    MEM_CMD = v.cmd; ADDR = v.addr; WDATA = v.wdata; BUS_ACK = 1'b0;
    vq.push_back(v);
    @(negedge CLK);
    chk({v.name, " stall_N"}, 32'(STALL), 32'd1);
    #1;
    c = 0;
    while (vq.size() != 0 && c < TO + 4) begin
      @(posedge CLK); #1;
      c++;
      BUS_ACK   = (c == v.ack_k);
      BUS_RDATA = (c == v.ack_k) ? v.brd : $urandom;
      @(negedge CLK); #1;
    end
    if (vq.size() != 0) begin
      chk({v.name, " completion_timeout"}, 32'd0, 32'd1);
      vq.delete();
    end
    @(posedge CLK); #1;
    MEM_CMD = 4'b0000;
    BUS_ACK = (v.ack_k > TO);   // late ACK in IDLE must be ignored
    @(negedge CLK);
    chk({v.name, " idle_req"}, 32'(BUS_REQ), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; MEM_CMD = 4'b0000; ADDR = '0; WDATA = '0;
    BUS_RDATA = '0; BUS_ACK = 1'b0;

    //        name      cmd      addr        wdata        brd          k  e_addr     be      we  e_wdata      e_rdata      req mis bus
    tbl.push_back(mk("lw",     CMD_LW,  32'h100, 32'h0,        32'hDEADBEEF, 3, 32'h100, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 3, 0, 0));
    tbl.push_back(mk("lb",     CMD_LB,  32'h103, 32'h0,        32'h80FF0000, 1, 32'h100, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 1, 0, 0));
    tbl.push_back(mk("lbu",    CMD_LBU, 32'h103, 32'h0,        32'h80FF0000, 1, 32'h100, 4'b1000, 0, 32'h0,        32'h00000080, 1, 0, 0));
    tbl.push_back(mk("sh",     CMD_SH,  32'h202, 32'h1234ABCD, 32'h55555555, 2, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h00000080, 2, 0, 0));
    tbl.push_back(mk("lw_mis", CMD_LW,  32'h101, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 0, 32'h0,        32'h0,        0, 1, 0));
    tbl.push_back(mk("sw_to",  CMD_SW,  32'h300, 32'hCAFEF00D, 32'h0,        5, 32'h300, 4'b1111, 1, 32'hCAFEF00D, 32'h0,        4, 0, 1));
    tbl.push_back(mk("lh_edge",CMD_LH,  32'h402, 32'h0,        32'h80017FFF, 4, 32'h400, 4'b1100, 0, 32'h0,        32'hFFFF8001, 4, 0, 0));
    tbl.push_back(mk("lhu",    CMD_LHU, 32'h400, 32'h0,        32'h8001F00F, 1, 32'h400, 4'b0011, 0, 32'h0,        32'h0000F00F, 1, 0, 0));
    tbl.push_back(mk("sb",     CMD_SB,  32'h501, 32'h000000A5, 32'h12121212, 1, 32'h500, 4'b0010, 1, 32'hA5A5A5A5, 32'h0000F00F, 1, 0, 0));
    tbl.push_back(mk("lh_mis", CMD_LH,  32'h503, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 0, 32'h0,        32'h0,        0, 1, 0));
    tbl.push_back(mk("lb2",    CMD_LB,  32'h502, 32'h0,        32'h12345678, 2, 32'h500, 4'b0100, 0, 32'h0,        32'h00000034, 2, 0, 0));
    tbl.push_back(mk("sw",     CMD_SW,  32'h604, 32'h11223344, 32'h0,        1, 32'h604, 4'b1111, 1, 32'h11223344, 32'h00000034, 1, 0, 0));
    tbl.push_back(mk("lhu_mis",CMD_LHU, 32'h601, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 0, 32'h0,        32'h0,        0, 1, 0));

    // Reset state
    #2;
    chk("rst bus_req",  32'(BUS_REQ), 32'd0);
    chk("rst bus_we",   32'(BUS_WE), 32'd0);
    chk("rst bus_addr", BUS_ADDR, 32'd0);
    chk("rst bus_be",   32'(BUS_BE), 32'd0);
    chk("rst rdata",    RDATA, 32'd0);
    chk("rst exc",      32'({EXC_MISALIGN, EXC_BUS}), 32'd0);
    chk("rst stall",    32'(STALL), 32'd0);
    @(posedge CLK); #1; RST = 1'b0;
    mon_en = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset asserted two cycles into BUSY, then a late ACK
    mon_en = 1'b0;
    @(posedge CLK); #1;
    MEM_CMD = CMD_LW; ADDR = 32'h700; BUS_ACK = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); chk("rstbusy req1", 32'(BUS_REQ), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK); chk("rstbusy req2", 32'(BUS_REQ), 32'd1);
    chk("rstbusy addr", BUS_ADDR, 32'h700);
    #2 RST = 1'b1;
    #1;
    chk("rstbusy req_async", 32'(BUS_REQ), 32'd0);
    chk("rstbusy addr0",     BUS_ADDR, 32'd0);
    chk("rstbusy be0",       32'(BUS_BE), 32'd0);
    chk("rstbusy rdata0",    RDATA, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; MEM_CMD = 4'b0000; BUS_ACK = 1'b1; BUS_RDATA = 32'hFFFFFFFF;
    @(negedge CLK); chk("rstbusy late_ack_req", 32'(BUS_REQ), 32'd0);
    @(posedge CLK); #1; BUS_ACK = 1'b0;
    @(negedge CLK); chk("rstbusy late_ack_rdata", RDATA, 32'd0);
    mon_en = 1'b1;
    run(mk("lw_after_rst", CMD_LW, 32'h704, 32'h0, 32'h600DCAFE, 2, 32'h704, 4'b1111, 0, 32'h0, 32'h600DCAFE, 2, 0, 0));

    // Command held through DONE: not accepted until the following IDLE cycle
    mon_en = 1'b0;
    @(posedge CLK); #1;
    MEM_CMD = CMD_LW; ADDR = 32'h800; BUS_ACK = 1'b0;
    @(posedge CLK); #1; BUS_ACK = 1'b1; BUS_RDATA = 32'h0BADF00D;
    @(negedge CLK); chk("b2b req", 32'(BUS_REQ), 32'd1);
    @(posedge CLK); #1; BUS_ACK = 1'b0;
    @(negedge CLK);
    chk("b2b done_stall", 32'(STALL), 32'd0);
    chk("b2b done_rdata", RDATA, 32'h0BADF00D);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("b2b idle_req",   32'(BUS_REQ), 32'd0);
    chk("b2b idle_stall", 32'(STALL), 32'd1);
    @(posedge CLK); #1; BUS_ACK = 1'b1; BUS_RDATA = 32'h76543210;
    @(negedge CLK); chk("b2b second_req", 32'(BUS_REQ), 32'd1);
    @(posedge CLK); #1; BUS_ACK = 1'b0; MEM_CMD = 4'b0000;
    @(negedge CLK); chk("b2b second_rdata", RDATA, 32'h76543210);
    @(posedge CLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
